// File: rtl/fp_minmax_tracker.sv
// Streaming max/min reduction over a frame of sign-magnitude floating-point samples.
// Reports first-occurrence indices, sample count, NaN and overflow flags per frame.
module fp_minmax_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [IDX_WIDTH-1:0]  out_max_idx,
    output logic [IDX_WIDTH-1:0]  out_min_idx,
    output logic [IDX_WIDTH:0]    out_count,
    output logic                  out_nan,
    output logic                  out_ovf
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the producer holds data stable until the transfer.

    localparam int MAN_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH:0] COUNT_FULL = {1'b1, {IDX_WIDTH{1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH-1:0] max_r, min_r;
    logic [IDX_WIDTH-1:0]  max_idx_r, min_idx_r;
    logic [IDX_WIDTH:0]    count_r;
    logic                  nan_r, ovf_r, seen_r;
    logic                  accept, sample_nan;
    logic [IDX_WIDTH-1:0]  sample_idx;

    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
        return (&v[DATA_WIDTH-2 -: EXP_WIDTH]) && (|v[MAN_WIDTH-1:0]);
    endfunction

    // True when a orders strictly above b; +0 and -0 are equal.
    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] ma, mb;
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (ma == '0 && mb == '0) return 1'b0;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return !a[DATA_WIDTH-1];
        if (!a[DATA_WIDTH-1]) return ma > mb;
        return ma < mb;
    endfunction

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !rst;
                if (in_valid && !rst && in_last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    assign accept     = in_valid && in_ready;
    assign sample_nan = is_nan(in_data);
    // Once the count passes the index range, every later sample reports the top index.
    assign sample_idx = count_r[IDX_WIDTH] ? {IDX_WIDTH{1'b1}} : count_r[IDX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst || (out_valid && out_ready)) begin
            max_r     <= '0;
            min_r     <= '0;
            max_idx_r <= '0;
            min_idx_r <= '0;
            count_r   <= '0;
            nan_r     <= 1'b0;
            ovf_r     <= 1'b0;
            seen_r    <= 1'b0;
        end else if (accept) begin
            if (count_r == COUNT_FULL) ovf_r <= 1'b1;
            else                       count_r <= count_r + 1'b1;
            if (sample_nan) begin
                nan_r <= 1'b1;
            end else if (!seen_r) begin
                seen_r    <= 1'b1;
                max_r     <= in_data;
                min_r     <= in_data;
                max_idx_r <= sample_idx;
                min_idx_r <= sample_idx;
            end else begin
                if (greater(in_data, max_r)) begin
                    max_r     <= in_data;
                    max_idx_r <= sample_idx;
                end
                if (greater(min_r, in_data)) begin
                    min_r     <= in_data;
                    min_idx_r <= sample_idx;
                end
            end
        end
    end

    // A frame with no ordinary sample reports the canonical quiet NaN.
    assign out_max     = seen_r ? max_r : (nan_r ? QNAN : '0);
    assign out_min     = seen_r ? min_r : (nan_r ? QNAN : '0);
    assign out_max_idx = max_idx_r;
    assign out_min_idx = min_idx_r;
    assign out_count   = count_r;
    assign out_nan     = nan_r;
    assign out_ovf     = ovf_r;

endmodule

// File: tb/tb_fp_minmax_tracker.sv
// Directed bench for fp_minmax_tracker: a default-width instance for the main frames
// and a two-bit-index instance for the overflow frame.
module tb_fp_minmax_tracker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [31:0] in_data, out_max, out_min;
  logic [7:0]  out_max_idx, out_min_idx;
  logic [8:0]  out_count;
  logic        out_nan, out_ovf;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_max, b_min;
  logic [1:0]  b_max_idx, b_min_idx;
  logic [2:0]  b_count;
  logic        b_nan, b_ovf;

  int errors = 0;
  int checks = 0;

  fp_minmax_tracker #(.DATA_WIDTH(32), .EXP_WIDTH(8), .IDX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_min(out_min), .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
    .out_count(out_count), .out_nan(out_nan), .out_ovf(out_ovf)
  );

  fp_minmax_tracker #(.DATA_WIDTH(32), .EXP_WIDTH(8), .IDX_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_max(b_max),
    .out_min(b_min), .out_max_idx(b_max_idx), .out_min_idx(b_min_idx),
    .out_count(b_count), .out_nan(b_nan), .out_ovf(b_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [31:0] d, input logic last);
    int n = 0;
    in_data = d;
    in_last = last;
    if (sel) b_in_valid = 1'b1;
    else     in_valid = 1'b1;
    @(negedge clk);
    while (!(sel ? b_in_ready : in_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("send_wait", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    b_in_valid = 1'b0;
    in_last = 1'b0;
    in_data = $urandom;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      in_data = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input string name, input bit sel,
                              input logic [31:0] mx, input int mxi,
                              input logic [31:0] mn, input int mni,
                              input int cnt, input bit nan, input bit ovf);
    int n = 0;
    @(negedge clk);
    check($sformatf("%s.latency", name), 64'(sel ? b_out_valid : out_valid), 64'd1);
    while (!(sel ? b_out_valid : out_valid) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("%s.max", name), 64'(sel ? b_max : out_max), 64'(mx));
    check($sformatf("%s.max_idx", name), 64'(sel ? 8'(b_max_idx) : out_max_idx), 64'(mxi));
    check($sformatf("%s.min", name), 64'(sel ? b_min : out_min), 64'(mn));
    check($sformatf("%s.min_idx", name), 64'(sel ? 8'(b_min_idx) : out_min_idx), 64'(mni));
    check($sformatf("%s.count", name), 64'(sel ? 9'(b_count) : out_count), 64'(cnt));
    check($sformatf("%s.nan", name), 64'(sel ? b_nan : out_nan), 64'(nan));
    check($sformatf("%s.ovf", name), 64'(sel ? b_ovf : out_ovf), 64'(ovf));
    check($sformatf("%s.in_ready_hold", name), 64'(sel ? b_in_ready : in_ready), 64'd0);
    if (sel) b_out_ready = 1'b1;
    else     out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    b_in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_max", 64'(out_max), 64'd0);
    check("rst.out_min", 64'(out_min), 64'd0);
    check("rst.count", 64'(out_count), 64'd0);
    check("rst.flags", 64'({out_nan, out_ovf, out_max_idx, out_min_idx}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Mixed signs, back-to-back
    send(0, 32'h3F800000, 0);
    send(0, 32'hC0000000, 0);
    send(0, 32'h40600000, 1);
    expect_frame("mixed", 0, 32'h40600000, 2, 32'hC0000000, 1, 3, 0, 0);

    // All negative, with an idle gap mid-frame
    send(0, 32'hC0000000, 0);
    idle(3);
    send(0, 32'hBF800000, 1);
    expect_frame("neg", 0, 32'hBF800000, 1, 32'hC0000000, 0, 2, 0, 0);

    // Zeros, NaN and infinity
    send(0, 32'h80000000, 0);
    send(0, 32'h00000000, 0);
    send(0, 32'h7FC00000, 0);
    send(0, 32'h7F800000, 1);
    expect_frame("zeros", 0, 32'h7F800000, 3, 32'h80000000, 0, 4, 1, 0);

    // +0 then -0: first-seen zero pattern kept for both
    send(0, 32'h00000000, 0);
    send(0, 32'h80000000, 1);
    expect_frame("ztie", 0, 32'h00000000, 0, 32'h00000000, 0, 2, 0, 0);

    // Leading NaN, -inf and signalling NaN among ordinary samples
    send(0, 32'hFFC00000, 0);
    send(0, 32'hBF800000, 0);
    send(0, 32'hFF800000, 0);
    send(0, 32'h7F800001, 0);
    send(0, 32'h3F800000, 1);
    expect_frame("ninf", 0, 32'h3F800000, 4, 32'hFF800000, 2, 5, 1, 0);

    // Single all-NaN frame
    send(0, 32'h7FC00001, 1);
    expect_frame("allnan", 0, 32'h7FC00000, 0, 32'h7FC00000, 0, 1, 1, 0);

    // Backpressure: result held, new samples refused
    send(0, 32'h40000000, 0);
    send(0, 32'h40000000, 0);
    send(0, 32'h3F800000, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h7F000000 + 32'(i);
      @(negedge clk);
      check($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d.out_max", i), 64'(out_max), 64'h40000000);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    expect_frame("bp", 0, 32'h40000000, 0, 32'h3F800000, 2, 3, 0, 0);
    @(negedge clk);
    check("bp_after.in_ready", 64'(in_ready), 64'd1);
    check("bp_after.out_valid", 64'(out_valid), 64'd0);
    check("bp_after.count", 64'(out_count), 64'd0);
    @(posedge clk);
    #1;

    // Mid-frame reset discards partial frame
    send(0, 32'h40A00000, 0);
    send(0, 32'hC0E00000, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst.count", 64'(out_count), 64'd0);
    check("midrst.max", 64'(out_max), 64'd0);
    @(posedge clk);
    #1;
    send(0, 32'h3F800000, 1);
    expect_frame("midrst", 0, 32'h3F800000, 0, 32'h3F800000, 0, 1, 0, 0);

    // Overflow on the two-bit-index instance
    for (int i = 0; i < 6; i++) send(1, 32'h3F800000, i == 5);
    expect_frame("ovf", 1, 32'h3F800000, 0, 32'h3F800000, 0, 4, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
